// File: rtl/reduce_sum_pkg.sv
// Shared definitions for the sum-checksum stream format (transmitter and verifier).
package reduce_sum_pkg;

   localparam int DATA_W = 512;
   localparam int KEEP_W = DATA_W / 8;
   localparam int ID_W   = 6;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic [ID_W-1:0]   id;
      logic              last;
   } beat_t;

endpackage

// File: rtl/reduce_sum_hold.sv
// One-beat hold stage: a payload beat is released only alongside the next input beat,
// whose last flag becomes the released beat's last flag.
module reduce_sum_hold
   import reduce_sum_pkg::*;
(
   input  logic  clock,
   input  logic  reset,
   input  beat_t inp_beat,
   input  logic  inp_valid,
   output logic  inp_ready,
   output beat_t out_beat,
   output logic  out_valid,
   input  logic  out_ready
);

   beat_t hold;
   logic  hold_valid;
   logic  inp_fire;

   assign inp_ready = !hold_valid || out_ready;
   assign inp_fire  = inp_valid && inp_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         hold_valid <= 1'b0;
         hold       <= '0;
      end else if (inp_fire) begin
         if (inp_beat.last) begin
            hold_valid <= 1'b0;
         end else begin
            hold_valid <= 1'b1;
            hold       <= inp_beat;
         end
      end
   end

   // The trailer is never stored, so the held beat always inherits last from its successor.
   always_comb begin
      out_valid = hold_valid && inp_valid;
      out_beat  = '0;
      if (out_valid) begin
         out_beat      = hold;
         out_beat.last = inp_beat.last;
      end
   end

endmodule

// File: rtl/reduce_sum_verify.sv
// Checksum verifier: forwards payload with last moved onto the final payload beat, strips the
// trailer and emits one status pulse per packet plus a saturating mismatch counter.
module reduce_sum_verify
   import reduce_sum_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int ERR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] inp_data,
   input  logic              inp_valid,
   output logic              inp_ready,
   input  logic [KEEP_W-1:0] inp_keep,
   input  logic [ID_W-1:0]   inp_id,
   input  logic              inp_last,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [KEEP_W-1:0] out_keep,
   output logic [ID_W-1:0]   out_id,
   output logic              out_last,
   output logic              chk_valid,
   output logic              chk_ok,
   output logic [ID_W-1:0]   chk_id,
   output logic [CNT_W-1:0]  chk_beats,
   output logic [ERR_W-1:0]  err_count
);

   beat_t             in_beat;
   beat_t             fwd_beat;
   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  beat_cnt;
   logic              inp_fire;
   logic              sum_match;

   always_comb begin
      in_beat      = '0;
      in_beat.data = inp_data;
      in_beat.keep = inp_keep;
      in_beat.id   = inp_id;
      in_beat.last = inp_last;
   end

   reduce_sum_hold u_hold (
      .clock     (clock),
      .reset     (reset),
      .inp_beat  (in_beat),
      .inp_valid (inp_valid),
      .inp_ready (inp_ready),
      .out_beat  (fwd_beat),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_data  = fwd_beat.data;
   assign out_keep  = fwd_beat.keep;
   assign out_id    = fwd_beat.id;
   assign out_last  = fwd_beat.last;

   assign inp_fire  = inp_valid && inp_ready;
   assign sum_match = (acc == inp_data);

   always_ff @(posedge clock) begin
      if (!reset) begin
         acc       <= '0;
         beat_cnt  <= '0;
         chk_valid <= 1'b0;
         chk_ok    <= 1'b0;
         chk_id    <= '0;
         chk_beats <= '0;
         err_count <= '0;
      end else begin
         chk_valid <= 1'b0;
         if (inp_fire) begin
            if (inp_last) begin
               chk_valid <= 1'b1;
               chk_ok    <= sum_match;
               chk_id    <= inp_id;
               chk_beats <= beat_cnt;
               acc       <= '0;
               beat_cnt  <= '0;
               if (!sum_match && (err_count != '1)) begin
                  err_count <= err_count + ERR_W'(1);
               end
            end else begin
               acc      <= acc + inp_data;
               beat_cnt <= beat_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_reduce_sum_verify.sv
// Randomized bench for reduce_sum_verify, scored against a packet-level reference model.
module tb_reduce_sum_verify;
   import reduce_sum_pkg::*;

   localparam int CNT_W = 16;
   localparam int ERR_W = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] inp_data;
   logic              inp_valid;
   logic              inp_ready;
   logic [KEEP_W-1:0] inp_keep;
   logic [ID_W-1:0]   inp_id;
   logic              inp_last;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [KEEP_W-1:0] out_keep;
   logic [ID_W-1:0]   out_id;
   logic              out_last;
   logic              chk_valid;
   logic              chk_ok;
   logic [ID_W-1:0]   chk_id;
   logic [CNT_W-1:0]  chk_beats;
   logic [ERR_W-1:0]  err_count;

   reduce_sum_verify #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
      .clock(clock), .reset(reset),
      .inp_data(inp_data), .inp_valid(inp_valid), .inp_ready(inp_ready),
      .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_keep(out_keep), .out_id(out_id), .out_last(out_last),
      .chk_valid(chk_valid), .chk_ok(chk_ok), .chk_id(chk_id),
      .chk_beats(chk_beats), .err_count(err_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: beats accepted but not yet forwarded, running packet sum and count,
   // the status expected on the next cycle and the last reported status values.
   beat_t             m_pend[$];
   logic [DATA_W-1:0] m_sum;
   int                m_cnt;
   logic              m_stat_due;
   logic              m_ok;
   logic [ID_W-1:0]   m_id;
   logic [CNT_W-1:0]  m_beats;
   logic [ERR_W-1:0]  m_err;
   bit                accepted;
   bit                rand_rdy;
   int                pulses;
   int                trailers;

   task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic beat_t mk_beat(input logic [DATA_W-1:0] d, input logic l);
      beat_t b;
      b.data = d;
      for (int i = 0; i < KEEP_W / 32; i++) b.keep[i*32 +: 32] = $urandom;
      b.id   = ID_W'($urandom_range(0, (1 << ID_W) - 1));
      b.last = l;
      return b;
   endfunction

   task automatic model_clear();
      m_pend.delete();
      m_sum = '0; m_cnt = 0; m_stat_due = 1'b0;
      m_ok = 1'b0; m_id = '0; m_beats = '0; m_err = '0;
   endtask

   // One clock: drive, check combinational outputs and status at negedge, update model.
   task automatic cycle(input logic v, input beat_t b, input logic rdy);
      bit   pend;
      inp_valid = v; inp_data = b.data; inp_keep = b.keep; inp_id = b.id;
      inp_last = b.last; out_ready = rdy;
      @(negedge clock);
      pend = (m_pend.size() > 0);
      check("out_valid", out_valid, v && pend);
      if (v && pend) begin
         check("out_data", out_data, m_pend[0].data);
         check("out_keep", out_keep, m_pend[0].keep);
         check("out_id", out_id, m_pend[0].id);
         check("out_last", out_last, b.last);
      end else begin
         check("out_idle", {out_data, out_keep, out_id, out_last}, '0);
      end
      check("inp_ready", inp_ready, !pend || rdy);
      check("chk_valid", chk_valid, m_stat_due);
      check("chk_ok", chk_ok, m_ok);
      check("chk_id", chk_id, m_id);
      check("chk_beats", chk_beats, m_beats);
      check("err_count", err_count, m_err);
      if (chk_valid) pulses++;
      m_stat_due = 1'b0;
      accepted = v && inp_ready;
      if (accepted) begin
         if (pend) void'(m_pend.pop_front());
         if (b.last) begin
            trailers++;
            m_stat_due = 1'b1;
            m_ok = (m_sum == b.data);
            m_id = b.id;
            m_beats = CNT_W'(m_cnt);
            if (!m_ok && m_err != '1) m_err = m_err + 1;
            m_sum = '0; m_cnt = 0;
         end else begin
            m_pend.push_back(b);
            m_sum = m_sum + b.data;
            m_cnt++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, mk_beat(rnd_data(), 1'b0), 1'b1);
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic l);
      beat_t b;
      int    n;
      b = mk_beat(d, l);
      n = 0;
      do begin
         cycle(1'b1, b, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
         n++;
      end while (!accepted && n < 200);
      if (!accepted) check("send_timeout", 0, 1);
   endtask

   task automatic do_reset();
      inp_valid = 1'b0; inp_last = 1'b0; out_ready = 1'b1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      model_clear();
   endtask

   logic [DATA_W-1:0] all_ones;
   logic [DATA_W-1:0] psum;

   initial begin
      rand_rdy = 0; pulses = 0; trailers = 0;
      inp_data = '0; inp_keep = '0; inp_id = '0;
      do_reset();
      idle(2);

      // directed packets
      send(1, 0); send(2, 0); send(3, 0); send(6, 1); idle(1);
      check("t1_ok", chk_ok, 1);
      check("t1_beats", chk_beats, 3);
      send(1, 0); send(2, 0); send(3, 0); send(7, 1); idle(1);
      check("t2_ok", chk_ok, 0);
      check("t2_err", err_count, 1);
      send(0, 1); idle(1);
      check("t3a_ok", chk_ok, 1);
      check("t3a_beats", chk_beats, 0);
      send(5, 1); idle(1);
      check("t3b_ok", chk_ok, 0);
      check("t3b_beats", chk_beats, 0);
      all_ones = '1;
      send(all_ones, 0); send(1, 0); send(0, 1); idle(1);
      check("t4_ok", chk_ok, 1);

      // 64-beat packet under random backpressure and input gaps
      rand_rdy = 1;
      psum = '0;
      for (int i = 0; i < 64; i++) begin
         logic [DATA_W-1:0] d;
         d = rnd_data();
         psum = psum + d;
         send(d, 0);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      send(psum, 1); idle(1);
      check("t5_ok", chk_ok, 1);
      check("t5_beats", chk_beats, 64);

      // mixed random packets, some good, some corrupted
      for (int p = 0; p < 12; p++) begin
         int n;
         n = $urandom_range(0, 6);
         psum = '0;
         for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] d;
            d = rnd_data();
            psum = psum + d;
            send(d, 0);
         end
         send($urandom_range(0, 1) ? psum : rnd_data(), 1);
      end
      rand_rdy = 0;
      idle(1);

      // abort mid-packet
      send(rnd_data(), 0); send(rnd_data(), 0);
      do_reset();
      idle(1);
      send(4, 0); send(4, 1); idle(1);
      check("t6_ok", chk_ok, 1);
      check("t6_beats", chk_beats, 1);
      check("t6_err", err_count, 0);
      check("pulse_count", pulses, trailers);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
